// File: rtl/dm_arbiter.sv
// dm_arbiter: two-requester round-robin arbiter in front of a single-port
// 32-bit data memory. Each accepted request runs IDLE -> ACCESS -> RESP.
//
// Ports
//   clk, reset              clock; asynchronous active-low reset
//   m0_* / m1_*             requester ports: req, we, addr, wdata in;
//                           gnt, rvalid, rdata, err out (all registered)
//   mem_we/addr/wdata       registered strobe, word index and data to memory
//   mem_rdata               combinational read data from memory at mem_addr
module dm_arbiter #(
  parameter int unsigned DEPTH = 3072,
  parameter int unsigned AW    = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [31:0]   m0_addr,
  input  logic [31:0]   m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [31:0]   m0_rdata,
  output logic          m0_err,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [31:0]   m1_addr,
  input  logic [31:0]   m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [31:0]   m1_rdata,
  output logic          m1_err,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam int unsigned DW = 32;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          id_q, id_d;
  logic          we_q, we_d;
  logic          err_q, err_d;
  logic          last_q, last_d;
  logic [AW-1:0] word_q, word_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic          rv0_q, rv0_d, rv1_q, rv1_d;
  logic          oerr0_q, oerr0_d, oerr1_q, oerr1_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic          mem_we_q, mem_we_d;

  logic          win_id_c;
  logic          win_we_c;
  logic [DW-1:0] win_addr_c;
  logic [DW-1:0] win_wdata_c;
  logic          win_err_c;
  logic [DW-1:0] load_data_c;

  // Misaligned, beyond the memory, or upper address bits set.
  function automatic logic addr_err(input logic [DW-1:0] a);
    logic [AW-1:0] w;
    w = a[AW+1:2];
    return (a[1:0] != 2'b00) || (DW'(w) >= DEPTH) || ((a >> (AW + 2)) != '0);
  endfunction

  // On a tie the requester not served last wins; otherwise the lone requester.
  assign win_id_c    = (m0_req && m1_req) ? ~last_q : m1_req;
  assign win_we_c    = win_id_c ? m1_we    : m0_we;
  assign win_addr_c  = win_id_c ? m1_addr  : m0_addr;
  assign win_wdata_c = win_id_c ? m1_wdata : m0_wdata;
  assign win_err_c   = addr_err(win_addr_c);

  // Only an error-free load returns memory data; stores and errors return 0.
  assign load_data_c = (!we_q && !err_q) ? mem_rdata : '0;

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      id_q     <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      last_q   <= 1'b1;
      word_q   <= '0;
      wdata_q  <= '0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      rv0_q    <= 1'b0;
      rv1_q    <= 1'b0;
      oerr0_q  <= 1'b0;
      oerr1_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      mem_we_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      we_q     <= we_d;
      err_q    <= err_d;
      last_q   <= last_d;
      word_q   <= word_d;
      wdata_q  <= wdata_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      rv0_q    <= rv0_d;
      rv1_q    <= rv1_d;
      oerr0_q  <= oerr0_d;
      oerr1_q  <= oerr1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      mem_we_q <= mem_we_d;
    end
  end

  // Next-state and next-output logic; pulses default low every cycle.
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    we_d     = we_q;
    err_d    = err_q;
    last_d   = last_q;
    word_d   = word_q;
    wdata_d  = wdata_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    rv0_d    = 1'b0;
    rv1_d    = 1'b0;
    oerr0_d  = 1'b0;
    oerr1_d  = 1'b0;
    rdata0_d = '0;
    rdata1_d = '0;
    mem_we_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          state_d  = ACCESS;
          id_d     = win_id_c;
          we_d     = win_we_c;
          err_d    = win_err_c;
          last_d   = win_id_c;
          word_d   = win_addr_c[AW+1:2];
          wdata_d  = win_wdata_c;
          gnt0_d   = ~win_id_c;
          gnt1_d   = win_id_c;
          // Strobe is registered so it is high exactly for the ACCESS cycle.
          mem_we_d = win_we_c && !win_err_c;
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (id_q) begin
          rv1_d    = 1'b1;
          oerr1_d  = err_q;
          rdata1_d = load_data_c;
        end else begin
          rv0_d    = 1'b1;
          oerr0_d  = err_q;
          rdata0_d = load_data_c;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign m0_gnt    = gnt0_q;
  assign m1_gnt    = gnt1_q;
  assign m0_rvalid = rv0_q;
  assign m1_rvalid = rv1_q;
  assign m0_err    = oerr0_q;
  assign m1_err    = oerr1_q;
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = word_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: scoreboard bench for dm_arbiter with a behavioural memory.
module tb_dm_arbiter;

  localparam int unsigned DEPTH = 3072;
  localparam int unsigned AW    = 12;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [31:0]   m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic          m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0]   m0_rdata, m1_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  exp_t exp0[$];
  exp_t exp1[$];
  int   gnt_id_q[$];
  int   gnt_cyc_q[$];
  int   last_gnt[2];
  int   cyc = 0;
  int   wcnt = 0;
  int   last_waddr = -1;
  int   n_checks = 0;
  int   n_fail = 0;

  dm_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign mem_rdata = (32'(mem_addr) < DEPTH) ? mem[mem_addr] : 32'h0;

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wcnt       = wcnt + 1;
      last_waddr = int'(mem_addr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic exp_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= DEPTH * 4);
  endfunction

  task automatic push_exp(input int id, input logic we, input logic [31:0] a,
                          input logic [31:0] wd);
    exp_t e;
    e.err   = exp_err(a);
    e.rdata = 32'h0;
    if (!e.err) begin
      if (we) ref_mem[a >> 2] = wd;
      else    e.rdata = ref_mem[a >> 2];
    end
    if (id == 0) exp0.push_back(e);
    else         exp1.push_back(e);
  endtask

  // Issue one request and hold it until granted; keep leaves req high.
  task automatic drive(input int id, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input bit keep);
    bit seen;
    seen = 1'b0;
    push_exp(id, we, a, wd);
    if (id == 0) begin
      m0_we = we; m0_addr = a; m0_wdata = wd; m0_req = 1'b1;
    end else begin
      m1_we = we; m1_addr = a; m1_wdata = wd; m1_req = 1'b1;
    end
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clk); #1;
      seen = (id == 0) ? m0_gnt : m1_gnt;
    end
    if (!seen) chk("gnt_timeout", 32'd0, 32'd1);
    if (!keep) begin
      if (id == 0) m0_req = 1'b0;
      else         m1_req = 1'b0;
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk);
      done = (exp0.size() == 0) && (exp1.size() == 0);
    end
    if (!done) chk("rvalid_timeout", 32'(exp0.size() + exp1.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ctl"}, 32'({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, mem_we}), 32'd0);
    chk({tag, "_rdata"}, m0_rdata | m1_rdata, 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  // Grants from index base must alternate starting at first, 3 cycles apart.
  task automatic chk_gnt_order(input int base, input int n, input int first);
    if (gnt_id_q.size() < base + n) begin
      chk("gnt_count", 32'(gnt_id_q.size()), 32'(base + n));
    end else begin
      for (int k = 0; k < n; k++) begin
        chk("gnt_order", 32'(gnt_id_q[base + k]), 32'((first + k) % 2));
        if (k > 0) chk("gnt_spacing", 32'(gnt_cyc_q[base + k] - gnt_cyc_q[base + k - 1]), 32'd3);
      end
    end
  endtask

  // Response monitor: pops the per-requester scoreboard on every rvalid.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1) begin
      if (m0_gnt && m1_gnt) chk("dual_gnt", 32'd1, 32'd0);
      if (m0_gnt) begin
        gnt_id_q.push_back(0); gnt_cyc_q.push_back(cyc); last_gnt[0] = cyc;
      end
      if (m1_gnt) begin
        gnt_id_q.push_back(1); gnt_cyc_q.push_back(cyc); last_gnt[1] = cyc;
      end
      if (m0_rvalid) begin
        if (exp0.size() == 0) begin
          chk("m0_spurious_rvalid", 32'd1, 32'd0);
        end else begin
          e = exp0.pop_front();
          chk("m0_rdata", m0_rdata, e.rdata);
          chk("m0_err", 32'(m0_err), 32'(e.err));
          chk("m0_latency", 32'(cyc - last_gnt[0]), 32'd1);
          chk("m1_quiet", 32'(m1_rvalid || m1_err || (m1_rdata != 0)), 32'd0);
        end
      end
      if (m1_rvalid) begin
        if (exp1.size() == 0) begin
          chk("m1_spurious_rvalid", 32'd1, 32'd0);
        end else begin
          e = exp1.pop_front();
          chk("m1_rdata", m1_rdata, e.rdata);
          chk("m1_err", 32'(m1_err), 32'(e.err));
          chk("m1_latency", 32'(cyc - last_gnt[1]), 32'd1);
          chk("m0_quiet", 32'(m0_rvalid || m0_err || (m0_rdata != 0)), 32'd0);
        end
      end
    end
  end

  initial begin
    int c0, wc0, base;
    bit seen;
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem[i]     = (32'(i) * 32'h9E37_79B1) ^ 32'hA5A5_0000;
      ref_mem[i] = mem[i];
    end
    mem[4] = 32'hDEAD_BEEF; ref_mem[4] = 32'hDEAD_BEEF;
    reset = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b1;

    // Single load: gnt one cycle after the sampling edge, rvalid one later.
    c0 = cyc;
    drive(0, 1'b0, 32'h10, 32'h0, 1'b0);
    wait_idle();
    chk("single_gnt_cycle", 32'(last_gnt[0]), 32'(c0 + 1));

    // Store then load at the top word.
    wc0 = wcnt;
    drive(1, 1'b1, 32'h2FFC, 32'h1234_5678, 1'b0);
    wait_idle();
    chk("store_wcnt", 32'(wcnt), 32'(wc0 + 1));
    chk("store_waddr", 32'(last_waddr), 32'h0BFF);
    chk("store_mem", mem[12'hBFF], 32'h1234_5678);
    drive(1, 1'b0, 32'h2FFC, 32'h0, 1'b0);
    wait_idle();

    // Error cases: past the end, misaligned, upper bits set.
    wc0 = wcnt;
    drive(0, 1'b1, 32'h3000, 32'hFFFF_FFFF, 1'b0);
    drive(1, 1'b0, 32'h0002, 32'h0, 1'b0);
    drive(0, 1'b0, 32'h4000, 32'h0, 1'b0);
    wait_idle();
    chk("err_no_write", 32'(wcnt), 32'(wc0));

    // Contention after m0 was served last: m1 must win first, then alternate.
    base = gnt_id_q.size();
    fork
      begin
        drive(0, 1'b0, 32'h50, 32'h0, 1'b1);
        drive(0, 1'b1, 32'hA0, 32'hCAFE_F00D, 1'b1);
        drive(0, 1'b0, 32'h58, 32'h0, 1'b0);
      end
      begin
        drive(1, 1'b0, 32'h78, 32'h0, 1'b1);
        drive(1, 1'b0, 32'h7C, 32'h0, 1'b1);
        drive(1, 1'b0, 32'hA4, 32'h0, 1'b0);
      end
    join
    wait_idle();
    chk_gnt_order(base, 6, 1);

    // Reset during the ACCESS cycle of an m0 store aborts it.
    wc0 = wcnt;
    m0_we = 1'b1; m0_addr = 32'h20; m0_wdata = 32'hAAAA_5555; m0_req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk); #1;
      seen = m0_gnt;
    end
    chk("midrst_gnt_seen", 32'(seen), 32'd1);
    reset = 1'b0;
    m0_req = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_wcnt", 32'(wcnt), 32'(wc0));
    chk("midrst_mem", mem[8], ref_mem[8]);

    // Both request from the cycle reset releases: m0 wins the first tie.
    base = gnt_id_q.size();
    reset = 1'b1;
    fork
      begin
        drive(0, 1'b0, 32'hC8, 32'h0, 1'b1);
        drive(0, 1'b0, 32'hCC, 32'h0, 1'b0);
      end
      begin
        drive(1, 1'b0, 32'hF0, 32'h0, 1'b1);
        drive(1, 1'b0, 32'hF4, 32'h0, 1'b0);
      end
    join
    wait_idle();
    chk_gnt_order(base, 4, 0);
    chk("final_mem_we", 32'(mem_we), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
